// File: rtl/la_trace_pkg.sv
// Shared types and constants for the logic-analyzer trace decoder.
package la_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_e;

    typedef enum logic [1:0] {
        BEAT_PLAY,
        BEAT_NULL,
        BEAT_ERR
    } beat_e;

    localparam int RC_MSB   = 31;
    localparam int RC_LSB   = 24;
    localparam int DATA_MSB = 23;

    localparam logic [31:0] NULL_BEAT   = 32'h0;
    localparam logic [7:0]  GAP_CNT_MAX = 8'hFF;
    localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

    // A zero repeat count is only legal on the all-zero null beat.
    function automatic beat_e classify(input logic [31:0] beat);
        if (beat[RC_MSB:RC_LSB] != '0) return BEAT_PLAY;
        if (beat == NULL_BEAT)         return BEAT_NULL;
        return BEAT_ERR;
    endfunction

endpackage

// File: rtl/la_dec_fifo2.sv
// Two-entry input buffer; ready depends only on the registered fill count.
module la_dec_fifo2 #(
    parameter int W = 32
) (
    input  logic         axi_clk,
    input  logic         la_reset_n,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic         rd_pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         push, pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;
    assign pop      = rd_pop & ~empty;
    assign rd_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_clk or negedge la_reset_n) begin
        if (!la_reset_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge axi_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/la_trace_decoder.sv
// Replays a run-length-encoded trace stream as a per-sample waveform,
// with timestamp and packet/gap/error counters.
module la_trace_decoder
    import la_trace_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 8,
    parameter int TS_W   = 32
) (
    input  logic              axi_clk,
    input  logic              la_reset_n,
    input  logic [31:0]       s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic [1:0]        s_tuser,
    input  logic              replay_en,
    output logic [DATA_W-1:0] la_out,
    output logic              la_out_vld,
    output logic              gap_pulse,
    output logic [TS_W-1:0]   timestamp,
    output logic [15:0]       pkt_cnt,
    output logic [7:0]        gap_cnt,
    output logic [7:0]        err_cnt,
    output logic              buf_empty
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [DATA_W-1:0]   la_out_q, la_out_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [31:0] head;
    logic        fifo_empty, fifo_full, load;
    logic        unused_tuser;

    assign unused_tuser = ^s_tuser;

    la_dec_fifo2 #(.W(32)) u_fifo (
        .axi_clk    (axi_clk),
        .la_reset_n (la_reset_n),
        .wr_data    (s_tdata),
        .wr_valid   (s_tvalid),
        .wr_ready   (s_tready),
        .rd_pop     (load),
        .rd_data    (head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // The engine takes the next beat when idle, after a gap, or as the last sample of a run is consumed.
    assign load = ~fifo_empty &
                  ((state_q == IDLE) || (state_q == GAP) ||
                   ((state_q == PLAY) && replay_en && (remain_q == CNT_W'(1))));

    assign la_out     = la_out_q;
    assign la_out_vld = (state_q == PLAY) & replay_en;
    assign gap_pulse  = (state_q == GAP);
    assign timestamp  = ts_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign gap_cnt    = gap_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign buf_empty  = fifo_empty & (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        la_out_d  = la_out_q;
        ts_d      = ts_q;
        pkt_cnt_d = pkt_cnt_q + {15'd0, s_tvalid & s_tready & s_tlast};
        gap_cnt_d = gap_cnt_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            PLAY: begin
                if (replay_en) begin
                    remain_d = remain_q - CNT_W'(1);
                    ts_d     = ts_q + TS_W'(1);
                    if (remain_q == CNT_W'(1)) state_d = IDLE;
                end
            end
            GAP: begin
                state_d = IDLE;
                if (gap_cnt_q != GAP_CNT_MAX) gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // An error beat is dropped, leaving the engine where an empty buffer would have left it.
        if (load) begin
            case (classify(head))
                BEAT_PLAY: begin
                    state_d  = PLAY;
                    remain_d = CNT_W'(head[RC_MSB:RC_LSB]);
                    la_out_d = DATA_W'(head[DATA_MSB:0]);
                end
                BEAT_NULL: begin
                    state_d  = GAP;
                    la_out_d = '0;
                end
                default: begin
                    if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
                end
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge la_reset_n) begin
        if (!la_reset_n) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            la_out_q  <= '0;
            ts_q      <= '0;
            pkt_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            la_out_q  <= la_out_d;
            ts_q      <= ts_d;
            pkt_cnt_q <= pkt_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_la_trace_decoder.sv
// Directed bench for la_trace_decoder: replay, stall, gap, error, backpressure, reset.
module tb_la_trace_decoder;

    logic        axi_clk;
    logic        la_reset_n;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [1:0]  s_tuser;
    logic        replay_en;
    logic [23:0] la_out;
    logic        la_out_vld;
    logic        gap_pulse;
    logic [31:0] timestamp;
    logic [15:0] pkt_cnt;
    logic [7:0]  gap_cnt;
    logic [7:0]  err_cnt;
    logic        buf_empty;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [23:0] samples [$];
    int          sample_cyc [$];

    la_trace_decoder dut (
        .axi_clk    (axi_clk),
        .la_reset_n (la_reset_n),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .replay_en  (replay_en),
        .la_out     (la_out),
        .la_out_vld (la_out_vld),
        .gap_pulse  (gap_pulse),
        .timestamp  (timestamp),
        .pkt_cnt    (pkt_cnt),
        .gap_cnt    (gap_cnt),
        .err_cnt    (err_cnt),
        .buf_empty  (buf_empty)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    // Collect every valid replayed sample, sampled on the falling edge.
    always @(negedge axi_clk) begin
        if (la_out_vld) begin
            samples.push_back(la_out);
            sample_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] beat, input logic last);
        int guard;
        s_tdata  = beat;
        s_tlast  = last;
        s_tvalid = 1'b1;
        guard    = 0;
        while (!s_tready && guard < 200) begin
            tick();
            guard++;
        end
        if (!s_tready) begin
            total++;
            bad++;
            $error("FAIL send_timeout: observed=s_tready low expected=high");
        end
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_samples(input string tag, input int n, input logic [23:0] a,
                                 input int n_a, input logic [23:0] b);
        check({tag, "_count"}, samples.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [23:0] got;
            got = (i < samples.size()) ? samples[i] : 24'hxxxxxx;
            check($sformatf("%s_s%0d", tag, i), {8'd0, got}, {8'd0, (i < n_a) ? a : b});
        end
    endtask

    initial begin
        int guard;
        la_reset_n = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tuser    = 2'b11;
        replay_en  = 1'b0;

        // Reset state
        #12;
        check("rst_tready", s_tready, 1);
        check("rst_la_out", la_out, 0);
        check("rst_vld", la_out_vld, 0);
        check("rst_gap", gap_pulse, 0);
        check("rst_ts", timestamp, 0);
        check("rst_cnts", {pkt_cnt, gap_cnt, err_cnt}, 0);
        check("rst_empty", buf_empty, 1);
        la_reset_n = 1'b1;
        tick();

        // Basic replay: 3 x 0x0A then 2 x 0x05, no bubble
        samples.delete();
        sample_cyc.delete();
        replay_en = 1'b1;
        send(32'h03_00000A, 1'b0);
        send(32'h02_000005, 1'b1);
        tick(8);
        check_samples("basic", 5, 24'h00000A, 3, 24'h000005);
        if (sample_cyc.size() == 5)
            check("basic_contiguous", sample_cyc[4] - sample_cyc[0], 4);
        check("basic_ts", timestamp, 5);
        check("basic_empty", buf_empty, 1);
        check("basic_pkt", pkt_cnt, 1);
        check("basic_vld_idle", la_out_vld, 0);

        // Replay stall: replay_en toggles, 4 samples in 8 cycles
        replay_en = 1'b0;
        samples.delete();
        send(32'h04_123456, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            replay_en = (i % 2 == 0);
            tick();
        end
        replay_en = 1'b0;
        tick(2);
        check_samples("stall", 4, 24'h123456, 4, 24'h123456);
        check("stall_ts", timestamp, 9);

        // Null beat between two play beats
        send(32'h01_000011, 1'b0);
        send(32'h00_000000, 1'b0);
        send(32'h01_000022, 1'b0);
        check("null_full_tready", s_tready, 0);
        check("null_pre_out", la_out, 32'h11);
        replay_en = 1'b1;
        tick();
        check("gap_pulse", gap_pulse, 1);
        check("gap_out", la_out, 0);
        check("gap_vld", la_out_vld, 0);
        check("gap_ts", timestamp, 10);
        tick();
        check("gap_after_pulse", gap_pulse, 0);
        check("gap_cnt", gap_cnt, 1);
        check("gap_after_out", la_out, 32'h22);
        check("gap_after_ts", timestamp, 10);
        tick(2);
        check("null_end_ts", timestamp, 11);

        // Error beat: counted, dropped, output untouched
        replay_en = 1'b0;
        send(32'h00_0000FF, 1'b0);
        tick();
        check("err_cnt1", err_cnt, 1);
        check("err_out_hold", la_out, 32'h22);
        check("err_empty", buf_empty, 1);
        samples.delete();
        replay_en = 1'b1;
        send(32'h02_000033, 1'b0);
        tick(4);
        check_samples("err_next", 2, 24'h000033, 2, 24'h000033);
        replay_en = 1'b0;
        for (int i = 0; i < 299; i++) send(32'h00_0000FF, 1'b0);
        tick(3);
        check("err_sat", err_cnt, 255);
        check("err_ts", timestamp, 13);
        check("err_gap_cnt", gap_cnt, 1);

        // Backpressure: engine holds one beat, FIFO holds two, fourth waits
        samples.delete();
        s_tdata  = 32'h01_0000A1;
        s_tvalid = 1'b1;
        check("bp_ready0", s_tready, 1);
        tick();
        s_tdata = 32'h01_0000A2;
        tick();
        s_tdata = 32'h01_0000A3;
        tick();
        check("bp_full", s_tready, 0);
        s_tdata = 32'h01_0000A4;
        tick(3);
        check("bp_still_full", s_tready, 0);
        check("bp_hold_out", la_out, 32'hA1);
        replay_en = 1'b1;
        guard = 0;
        while (!s_tready && guard < 50) begin
            tick();
            guard++;
        end
        check("bp_recover", s_tready, 1);
        tick();
        s_tvalid = 1'b0;
        tick(8);
        check("bp_count", samples.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_s%0d", i), (i < samples.size()) ? {8'd0, samples[i]} : 32'hx,
                  32'hA1 + i);
        check("bp_ts", timestamp, 17);
        check("bp_empty", buf_empty, 1);

        // Reset mid-playback
        send(32'hFF_ABCDEF, 1'b0);
        tick(4);
        check("rstm_out", la_out, 32'hABCDEF);
        check("rstm_vld", la_out_vld, 1);
        #2;
        la_reset_n = 1'b0;
        #1;
        check("rstm_la_out", la_out, 0);
        check("rstm_vld0", la_out_vld, 0);
        check("rstm_ts", timestamp, 0);
        check("rstm_cnts", {pkt_cnt, gap_cnt, err_cnt}, 0);
        check("rstm_tready", s_tready, 1);
        check("rstm_empty", buf_empty, 1);
        @(negedge axi_clk);
        la_reset_n = 1'b1;
        samples.delete();
        send(32'h02_000077, 1'b0);
        tick(5);
        check_samples("rstm_replay", 2, 24'h000077, 2, 24'h000077);
        check("rstm_replay_ts", timestamp, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
